// File: rtl/spi_ram_responder.sv
// SPI mode-0 RAM target: oversampled csb/clk/mosi, byte-addressed array,
// READ/WRITE/RDMR/WRMR with byte, page and sequential address advance.
module spi_ram_responder #(
  parameter int unsigned MEM_ADDR_BITS   = 10,
  parameter int unsigned PAGE_BYTES_LOG2 = 5,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_csb,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [1:0] mode,
  output logic       busy,
  output logic       command_error
);
  localparam int unsigned AW    = MEM_ADDR_BITS;
  localparam int unsigned PW    = PAGE_BYTES_LOG2;
  localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;
  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_COMMAND, S_ADDR, S_RD_DATA, S_WR_DATA, S_MODE_OUT, S_MODE_IN, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] csb_sync, sclk_sync, mosi_sync;
  logic sclk_q;
  logic s_csb, s_sclk, s_mosi, sclk_rise_c, sclk_fall_c, byte_done_c, we_c;

  // Pin synchronizers; csb idles high so a reset never looks like a select
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csb_sync  <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
    end else begin
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign s_csb       = csb_sync[SYNC_STAGES-1];
  assign s_sclk      = sclk_sync[SYNC_STAGES-1];
  assign s_mosi      = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise_c = s_sclk & ~sclk_q;
  assign sclk_fall_c = ~s_sclk & sclk_q;

  state_t          state, state_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [1:0]      addr_cnt, addr_cnt_n;
  logic [7:0]      rx, rx_n, tx, tx_n, rx_byte_c;
  logic [AW-1:0]   idx, idx_n, idx_adv_c;
  logic [PW-1:0]   pg_lo_c;
  logic            is_read, is_read_n, fetch_pend, fetch_pend_n;
  logic            miso_n, oe_n, busy_n, cmd_err_n;
  logic [1:0]      mode_n;
  logic [7:0]      mem [DEPTH];

  assign rx_byte_c   = {rx[6:0], s_mosi};
  assign byte_done_c = sclk_rise_c && (bit_cnt == 3'd7);

  // Index after one byte under the current mode
  always_comb begin
    pg_lo_c   = idx[PW-1:0] + PW'(1);
    idx_adv_c = idx;
    case (mode)
      MODE_PAGE: idx_adv_c = {idx[AW-1:PW], pg_lo_c};
      MODE_SEQ:  idx_adv_c = idx + AW'(1);
      default:   idx_adv_c = idx;
    endcase
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    addr_cnt_n   = addr_cnt;
    rx_n         = rx;
    tx_n         = tx;
    idx_n        = idx;
    is_read_n    = is_read;
    fetch_pend_n = 1'b0;
    mode_n       = mode;
    miso_n       = spi_miso;
    cmd_err_n    = 1'b0;
    we_c         = 1'b0;

    if (sclk_rise_c) begin
      rx_n      = rx_byte_c;
      bit_cnt_n = bit_cnt + 3'd1;
    end
    if (sclk_fall_c && (state == S_RD_DATA || state == S_MODE_OUT)) begin
      miso_n = tx[7];
      tx_n   = {tx[6:0], 1'b0};
    end

    case (state)
      S_IDLE: begin
        bit_cnt_n  = 3'd0;
        addr_cnt_n = 2'd0;
        if (!s_csb) state_n = S_COMMAND;
      end
      S_COMMAND: if (byte_done_c) begin
        case (rx_byte_c)
          8'h03: begin state_n = S_ADDR; is_read_n = 1'b1; end
          8'h02: begin state_n = S_ADDR; is_read_n = 1'b0; end
          8'h05: begin state_n = S_MODE_OUT; tx_n = {mode, 6'b0}; end
          8'h01: state_n = S_MODE_IN;
          default: begin state_n = S_IGNORE; cmd_err_n = 1'b1; end
        endcase
      end
      S_ADDR: begin
        // Shifting all 24 bits through leaves only the low index bits
        if (sclk_rise_c) idx_n = AW'({idx, s_mosi});
        if (byte_done_c) begin
          addr_cnt_n = addr_cnt + 2'd1;
          if (addr_cnt == 2'd2) begin
            state_n      = is_read ? S_RD_DATA : S_WR_DATA;
            fetch_pend_n = is_read;
          end
        end
      end
      S_RD_DATA: begin
        if (fetch_pend) tx_n = mem[idx];
        if (byte_done_c) begin
          idx_n        = idx_adv_c;
          fetch_pend_n = 1'b1;
        end
      end
      S_WR_DATA: if (byte_done_c) begin
        we_c  = 1'b1;
        idx_n = idx_adv_c;
      end
      S_MODE_OUT: if (byte_done_c) tx_n = {mode, 6'b0};
      S_MODE_IN: if (byte_done_c) begin
        mode_n  = (rx_byte_c[7:6] == 2'b11) ? MODE_BYTE : rx_byte_c[7:6];
        state_n = S_IGNORE;
      end
      default: ;
    endcase

    // Deselect overrides anything completing in the same cycle
    if (s_csb) begin
      state_n      = S_IDLE;
      we_c         = 1'b0;
      mode_n       = mode;
      cmd_err_n    = 1'b0;
      fetch_pend_n = 1'b0;
    end

    oe_n   = (state_n == S_RD_DATA) || (state_n == S_MODE_OUT);
    if (!oe_n) miso_n = 1'b0;
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      bit_cnt       <= 3'd0;
      addr_cnt      <= 2'd0;
      rx            <= 8'h00;
      tx            <= 8'h00;
      idx           <= '0;
      is_read       <= 1'b0;
      fetch_pend    <= 1'b0;
      mode          <= MODE_SEQ;
      spi_miso      <= 1'b0;
      spi_miso_oe   <= 1'b0;
      busy          <= 1'b0;
      command_error <= 1'b0;
    end else begin
      state         <= state_n;
      bit_cnt       <= bit_cnt_n;
      addr_cnt      <= addr_cnt_n;
      rx            <= rx_n;
      tx            <= tx_n;
      idx           <= idx_n;
      is_read       <= is_read_n;
      fetch_pend    <= fetch_pend_n;
      mode          <= mode_n;
      spi_miso      <= miso_n;
      spi_miso_oe   <= oe_n;
      busy          <= busy_n;
      command_error <= cmd_err_n;
    end
  end

  // Array is not reset; committed writes survive rst
  always_ff @(posedge clk) begin
    if (we_c) mem[idx] <= rx_byte_c;
  end
endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed plus randomized bench for spi_ram_responder against a
// behavioural memory/mode model.
module tb_spi_ram_responder;
  localparam int HALF  = 50;
  localparam int DEPTH = 1024;
  localparam int PAGE  = 32;
  localparam int SYNC  = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic spi_csb = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, busy, command_error;
  logic [1:0] mode;

  int total = 0, bad = 0;
  logic [7:0] ref_mem [DEPTH];
  logic [1:0] ref_mode = 2'b01;
  logic [7:0] wq [$];
  int err_cnt = 0;
  bit err_prev = 0, err_run2 = 0, oe_watch = 0, oe_seen = 0;

  spi_ram_responder dut (
    .clk(clk), .rst(rst), .spi_csb(spi_csb), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mode(mode), .busy(busy), .command_error(command_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (command_error) err_cnt++;
    if (command_error && err_prev) err_run2 = 1;
    err_prev = command_error;
    if (oe_watch && spi_miso_oe) oe_seen = 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int adv(input int a);
    if (ref_mode == 2'b00) return a;
    if (ref_mode == 2'b10) return (a / PAGE) * PAGE + ((a + 1) % PAGE);
    return (a + 1) % DEPTH;
  endfunction

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nb; i--) begin
      spi_mosi = tx[i];
      #(HALF);
      rx[i] = spi_miso;
      spi_clk = 1'b1;
      #(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic begin_cmd();
    spi_csb = 1'b0;
    #(HALF);
  endtask

  task automatic end_cmd();
    #(HALF);
    spi_csb = 1'b1;
    #(HALF * 3);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] d;
    xfer(a[23:16], d);
    xfer(a[15:8], d);
    xfer(a[7:0], d);
  endtask

  task automatic do_write(input logic [23:0] a);
    logic [7:0] d;
    int ix;
    begin_cmd();
    xfer(8'h02, d);
    send_addr(a);
    ix = int'(a) % DEPTH;
    foreach (wq[k]) begin
      xfer(wq[k], d);
      ref_mem[ix] = wq[k];
      ix = adv(ix);
    end
    end_cmd();
  endtask

  task automatic do_read(input logic [23:0] a, input int n, input string tag);
    logic [7:0] d;
    int ix;
    begin_cmd();
    xfer(8'h03, d);
    send_addr(a);
    ix = int'(a) % DEPTH;
    for (int k = 0; k < n; k++) begin
      xfer(8'h00, d);
      check($sformatf("%s[%0d]@%0h", tag, k, ix), 32'(d), 32'(ref_mem[ix]));
      ix = adv(ix);
    end
    check({tag, "_oe"}, 32'(spi_miso_oe), 32'd1);
    end_cmd();
  endtask

  task automatic do_wrmr(input logic [7:0] b);
    logic [7:0] d;
    begin_cmd();
    xfer(8'h01, d);
    xfer(b, d);
    end_cmd();
    ref_mode = (b[7:6] == 2'b11) ? 2'b00 : b[7:6];
    check($sformatf("mode_after_wrmr_%0h", b), 32'(mode), 32'(ref_mode));
  endtask

  task automatic do_rdmr(input int nbytes);
    logic [7:0] d;
    begin_cmd();
    xfer(8'h05, d);
    for (int k = 0; k < nbytes; k++) begin
      xfer(8'h00, d);
      check($sformatf("rdmr[%0d]", k), 32'(d), 32'({ref_mode, 6'b0}));
    end
    end_cmd();
  endtask

  initial begin
    logic [7:0] d;
    logic [23:0] a;
    int n;

    // reset values
    #33;
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_oe", 32'(spi_miso_oe), 32'd0);
    check("rst_mode", 32'(mode), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmderr", 32'(command_error), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    #(HALF * 2);

    // sequential write then read back
    err_cnt = 0;
    wq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_write(24'h000010);
    do_read(24'h000010, 4, "seq_rd");
    check("seq_no_cmderr", 32'(err_cnt), 32'd0);

    // page mode with in-page wrap
    do_wrmr(8'h80);
    do_rdmr(2);
    wq = '{8'h11, 8'h22, 8'h33};
    do_write(24'h00001F);
    do_read(24'h00001F, 3, "page_rd");
    do_wrmr(8'h40);
    do_read(24'h000000, 2, "page_wrap_rd");
    check("page_wrap_lit", 32'(ref_mem[0]), 32'h22);

    // end-of-array wrap and upper address aliasing
    wq = '{8'hA5, 8'h5A};
    do_write(24'h0003FF);
    do_read(24'h1003FF, 2, "alias_rd");

    // unsupported opcode
    err_cnt = 0; err_run2 = 0; oe_seen = 0; oe_watch = 1;
    begin_cmd();
    xfer(8'h9F, d);
    xfer(8'($urandom), d);
    #(HALF);
    check("ign_busy", 32'(busy), 32'd1);
    end_cmd();
    oe_watch = 0;
    check("ign_err_count", 32'(err_cnt), 32'd1);
    check("ign_err_width", 32'(err_run2), 32'd0);
    check("ign_oe_seen", 32'(oe_seen), 32'd0);
    check("ign_busy_after", 32'(busy), 32'd0);

    // partial trailing byte is discarded
    wq = '{8'h3C};
    do_write(24'h000041);
    begin_cmd();
    xfer(8'h02, d);
    send_addr(24'h000040);
    xfer(8'h77, d);
    ref_mem[16'h40] = 8'h77;
    spi_bits(8'hF0, 4, d);
    #(HALF);
    @(negedge clk);
    spi_csb = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) break;
    end
    check("partial_busy_clr", 32'(n <= SYNC + 1), 32'd1);
    #(HALF * 3);
    do_read(24'h000040, 2, "partial_rd");

    // randomized mode/address/length traffic
    for (int t = 0; t < 8; t++) begin
      do_wrmr(8'($urandom));
      do_rdmr(1);
      a = 24'($urandom);
      n = $urandom_range(1, 5);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      do_write(a);
      do_read(a, n, $sformatf("rand%0d", t));
    end

    // async reset in the middle of a read
    do_wrmr(8'h80);
    @(negedge clk);
    begin_cmd();
    xfer(8'h03, d);
    send_addr(24'h000010);
    xfer(8'h00, d);
    check("midrst_byte0", 32'(d), 32'(ref_mem[16'h10]));
    spi_mosi = 1'b0;
    #(HALF);
    spi_clk = 1'b1;
    #20;
    rst = 1'b0;
    #1;
    check("midrst_oe", 32'(spi_miso_oe), 32'd0);
    check("midrst_mode", 32'(mode), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_miso", 32'(spi_miso), 32'd0);
    spi_clk = 1'b0;
    spi_csb = 1'b1;
    ref_mode = 2'b01;
    #(HALF);
    rst = 1'b1;
    @(negedge clk);
    #(HALF * 2);
    do_read(24'h000010, 4, "post_rst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
